// File: rtl/lfsr_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_pkg
// Shared definition of the 8-bit traffic LFSR used by the FIFO loopback
// source and by lfsr_stream_checker. Left shift, new bit0 = XNOR(bit7, bit3).
// Contents:
//   LFSR_W       - stream word width the polynomial is defined for
//   TAP_HI/LO    - feedback tap positions
//   lfsr_next()  - one step of the generator
//   chk_state_e  - checker FSM states (HALT reachable only with
//                  LFSR_CHK_STOP_ON_ERR_EN defined)
// -----------------------------------------------------------------------------
package lfsr_pkg;

    localparam int LFSR_W = 8;
    localparam int TAP_HI = 7;
    localparam int TAP_LO = 3;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        CHECK = 2'd1,
        HALT  = 2'd2
    } chk_state_e;

    // XNOR feedback: the all-ones word maps to itself, all-zeros does not.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] x);
        return {x[LFSR_W-2:0], ~(x[TAP_HI] ^ x[TAP_LO])};
    endfunction

endpackage

// File: rtl/lfsr_model.sv
// -----------------------------------------------------------------------------
// lfsr_model
// Prediction register for the checker. Holds the word expected next.
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset (value -> 0x00)
//   i_srst    in   synchronous clear (value -> 0x00)
//   i_load    in   seed: value <= lfsr_next(i_seed)
//   i_advance in   step: value <= lfsr_next(value)
//   i_seed    in   seed word
//   o_value   out  current prediction
// Priority: i_srst > i_load > i_advance.
// -----------------------------------------------------------------------------
module lfsr_model
    import lfsr_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_srst,
    input  logic              i_load,
    input  logic              i_advance,
    input  logic [LFSR_W-1:0] i_seed,
    output logic [LFSR_W-1:0] o_value
);

    logic [LFSR_W-1:0] r_value;

    // Prediction register: seed from received data, then advance from itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= {LFSR_W{1'b0}};
        end else if (i_srst) begin
            r_value <= {LFSR_W{1'b0}};
        end else if (i_load) begin
            r_value <= lfsr_next(i_seed);
        end else if (i_advance) begin
            r_value <= lfsr_next(r_value);
        end else begin
            r_value <= r_value;
        end
    end

    assign o_value = r_value;

endmodule

// File: rtl/lfsr_stream_checker.sv
// -----------------------------------------------------------------------------
// lfsr_stream_checker
// Sits on the FIFO read port, seeds an LFSR model from the first accepted
// word and checks every following word against the prediction.
// Ports:
//   clk            in   rising-edge clock
//   reset          in   asynchronous active-low reset
//   start          in   sync pulse: clear counters/captures, back to SYNC
//   in_valid       in   FIFO read data valid
//   in_data        in   FIFO read data
//   in_ready       out  word accepted when in_valid & in_ready (registered)
//   locked         out  model seeded, checking active
//   mismatch       out  one-cycle pulse, cycle after a bad word
//   word_count     out  words checked (seed excluded), saturating
//   err_count      out  mismatching words, saturating
//   first_err_got  out  received value of first mismatch
//   first_err_exp  out  expected value of first mismatch
//   err_seen       out  sticky mismatch flag
// Optional build macro: LFSR_CHK_STOP_ON_ERR_EN -- halt on the first
// mismatch (in_ready drops, counters freeze) until start or reset.
// -----------------------------------------------------------------------------
module lfsr_stream_checker
    import lfsr_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              locked,
    output logic              mismatch,
    output logic [CNT_W-1:0]  word_count,
    output logic [CNT_W-1:0]  err_count,
    output logic [DATA_W-1:0] first_err_got,
    output logic [DATA_W-1:0] first_err_exp,
    output logic              err_seen
);

    chk_state_e        r_state;
    chk_state_e        w_state_nxt;
    logic              r_ready;
    logic              r_locked;
    logic              r_mis;
    logic [CNT_W-1:0]  r_wc;
    logic [CNT_W-1:0]  r_ec;
    logic [DATA_W-1:0] r_got;
    logic [DATA_W-1:0] r_exp;
    logic              r_seen;

    logic              w_ready_nxt;
    logic              w_locked_nxt;
    logic              w_mis_nxt;
    logic [CNT_W-1:0]  w_wc_nxt;
    logic [CNT_W-1:0]  w_ec_nxt;
    logic [DATA_W-1:0] w_got_nxt;
    logic [DATA_W-1:0] w_exp_nxt;
    logic              w_seen_nxt;
    logic              w_load;
    logic              w_adv;
    logic              w_clr;
    logic              w_xfer;
    logic              w_bad;
    logic [LFSR_W-1:0] w_model;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    lfsr_model u_model (
        .clk       (clk),
        .rst_n     (reset),
        .i_srst    (w_clr),
        .i_load    (w_load),
        .i_advance (w_adv),
        .i_seed    (in_data),
        .o_value   (w_model)
    );

    assign w_xfer = in_valid & r_ready;
    assign w_bad  = (in_data != w_model);

    // Next-state and next-output logic; start overrides any transfer.
    always_comb begin
        w_state_nxt  = r_state;
        w_ready_nxt  = 1'b1;
        w_locked_nxt = r_locked;
        w_mis_nxt    = 1'b0;
        w_wc_nxt     = r_wc;
        w_ec_nxt     = r_ec;
        w_got_nxt    = r_got;
        w_exp_nxt    = r_exp;
        w_seen_nxt   = r_seen;
        w_load       = 1'b0;
        w_adv        = 1'b0;
        w_clr        = 1'b0;
        if (start) begin
            w_clr        = 1'b1;
            w_state_nxt  = SYNC;
            w_locked_nxt = 1'b0;
            w_wc_nxt     = {CNT_W{1'b0}};
            w_ec_nxt     = {CNT_W{1'b0}};
            w_got_nxt    = {DATA_W{1'b0}};
            w_exp_nxt    = {DATA_W{1'b0}};
            w_seen_nxt   = 1'b0;
        end else begin
            case (r_state)
                SYNC: begin
                    if (w_xfer) begin
                        w_load       = 1'b1;
                        w_locked_nxt = 1'b1;
                        w_state_nxt  = CHECK;
                    end else begin
                        w_load = 1'b0;
                    end
                end
                CHECK: begin
                    if (w_xfer) begin
                        // Advance from the prediction so one bad word costs one error.
                        w_adv    = 1'b1;
                        w_wc_nxt = sat_inc(r_wc);
                        if (w_bad) begin
                            w_mis_nxt = 1'b1;
                            w_ec_nxt  = sat_inc(r_ec);
                            if (!r_seen) begin
                                w_got_nxt  = in_data;
                                w_exp_nxt  = w_model;
                                w_seen_nxt = 1'b1;
                            end else begin
                                w_seen_nxt = r_seen;
                            end
`ifdef LFSR_CHK_STOP_ON_ERR_EN
                            w_state_nxt = HALT;
                            w_ready_nxt = 1'b0;
`endif
                        end else begin
                            w_mis_nxt = 1'b0;
                        end
                    end else begin
                        w_adv = 1'b0;
                    end
                end
                HALT: begin
`ifdef LFSR_CHK_STOP_ON_ERR_EN
                    w_ready_nxt = 1'b0;
`else
                    w_state_nxt = SYNC;
`endif
                end
                default: begin
                    w_state_nxt  = SYNC;
                    w_locked_nxt = 1'b0;
                end
            endcase
        end
    end

    // Checker state, counters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= SYNC;
            r_ready  <= 1'b0;
            r_locked <= 1'b0;
            r_mis    <= 1'b0;
            r_wc     <= {CNT_W{1'b0}};
            r_ec     <= {CNT_W{1'b0}};
            r_got    <= {DATA_W{1'b0}};
            r_exp    <= {DATA_W{1'b0}};
            r_seen   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ready  <= w_ready_nxt;
            r_locked <= w_locked_nxt;
            r_mis    <= w_mis_nxt;
            r_wc     <= w_wc_nxt;
            r_ec     <= w_ec_nxt;
            r_got    <= w_got_nxt;
            r_exp    <= w_exp_nxt;
            r_seen   <= w_seen_nxt;
        end
    end

    assign in_ready      = r_ready;
    assign locked        = r_locked;
    assign mismatch      = r_mis;
    assign word_count    = r_wc;
    assign err_count     = r_ec;
    assign first_err_got = r_got;
    assign first_err_exp = r_exp;
    assign err_seen      = r_seen;

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// -----------------------------------------------------------------------------
// tb_lfsr_stream_checker
// Directed scenarios plus a randomized stream, all checked cycle by cycle
// against a reference model of the checker's observable behaviour.
// Counters are built 4 bits wide so saturation is reached quickly.
// -----------------------------------------------------------------------------
module tb_lfsr_stream_checker;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;

    logic             clk;
    logic             reset;
    logic             start;
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_ready;
    logic             locked;
    logic             mismatch;
    logic [CNT_W-1:0] word_count;
    logic [CNT_W-1:0] err_count;
    logic [7:0]       first_err_got;
    logic [7:0]       first_err_exp;
    logic             err_seen;

    int n_cmp;
    int n_bad;

    // reference model of what the outputs should be
    logic     m_ready, m_locked, m_mis, m_seen, m_halt;
    int       m_wc, m_ec;
    int       m_pred, m_got, m_exp;

    lfsr_stream_checker #(.DATA_W(8), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .locked        (locked),
        .mismatch      (mismatch),
        .word_count    (word_count),
        .err_count     (err_count),
        .first_err_got (first_err_got),
        .first_err_exp (first_err_exp),
        .err_seen      (err_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // successor word: double mod 256, plus one when bit7 equals bit3
    function automatic int ref_next(input int x);
        int b7;
        int b3;
        b7 = (x / 128) % 2;
        b3 = (x / 8) % 2;
        return ((x * 2) % 256) + ((b7 == b3) ? 1 : 0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ready  = 1'b0;
        m_locked = 1'b0;
        m_mis    = 1'b0;
        m_seen   = 1'b0;
        m_halt   = 1'b0;
        m_wc     = 0;
        m_ec     = 0;
        m_pred   = 0;
        m_got    = 0;
        m_exp    = 0;
    endtask

    // apply one rising edge to the model, using the inputs currently driven
    task automatic model_edge();
        logic xfer;
        xfer  = in_valid & m_ready;
        m_mis = 1'b0;
        if (start) begin
            m_locked = 1'b0;
            m_seen   = 1'b0;
            m_halt   = 1'b0;
            m_wc     = 0;
            m_ec     = 0;
            m_got    = 0;
            m_exp    = 0;
            m_ready  = 1'b1;
        end else begin
            m_ready = !m_halt;
            if (xfer && !m_locked) begin
                m_pred   = ref_next(int'(in_data));
                m_locked = 1'b1;
            end else if (xfer) begin
                if (m_wc < CNT_MAX) m_wc++;
                if (int'(in_data) != m_pred) begin
                    m_mis = 1'b1;
                    if (m_ec < CNT_MAX) m_ec++;
                    if (!m_seen) begin
                        m_got  = int'(in_data);
                        m_exp  = m_pred;
                        m_seen = 1'b1;
                    end
`ifdef LFSR_CHK_STOP_ON_ERR_EN
                    m_halt  = 1'b1;
                    m_ready = 1'b0;
`endif
                end
                m_pred = ref_next(m_pred);
            end
        end
    endtask

    task automatic compare_all();
        chk("in_ready",      32'(in_ready),      32'(m_ready));
        chk("locked",        32'(locked),        32'(m_locked));
        chk("mismatch",      32'(mismatch),      32'(m_mis));
        chk("word_count",    32'(word_count),    32'(m_wc));
        chk("err_count",     32'(err_count),     32'(m_ec));
        chk("first_err_got", 32'(first_err_got), 32'(m_got));
        chk("first_err_exp", 32'(first_err_exp), 32'(m_exp));
        chk("err_seen",      32'(err_seen),      32'(m_seen));
    endtask

    task automatic step(input logic s, input logic v, input logic [7:0] d);
        @(negedge clk);
        start    = s;
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    // reset asserted mid-cycle with a word on the bus; outputs must clear at once
    task automatic mid_reset(input logic [7:0] d);
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        step(1'b0, 1'b0, 8'h00);
    endtask

    logic [7:0] clean_words [8];
    logic [7:0] bad_words   [6];

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        model_reset();
        clean_words = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1E, 8'h3C, 8'h78};
        bad_words   = '{8'h01, 8'h03, 8'h07, 8'h0E, 8'h1E, 8'h3C};

        // reset state
        @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        reset = 1'b1;
        step(1'b0, 1'b0, 8'h00);
        chk("ready_after_rst", 32'(in_ready), 32'd1);

        // clean stream
        foreach (clean_words[i]) step(1'b0, 1'b1, clean_words[i]);
        chk("clean_locked", 32'(locked), 32'd1);
        chk("clean_wc", 32'(word_count), 32'd7);
        chk("clean_ec", 32'(err_count), 32'd0);
        chk("clean_seen", 32'(err_seen), 32'd0);

        // single corruption
        step(1'b1, 1'b0, 8'h00);
        foreach (bad_words[i]) begin
            step(1'b0, 1'b1, bad_words[i]);
            if (i == 3) chk("corrupt_pulse", 32'(mismatch), 32'd1);
        end
        chk("corrupt_ec", 32'(err_count), 32'd1);
        chk("corrupt_got", 32'(first_err_got), 32'h0E);
        chk("corrupt_exp", 32'(first_err_exp), 32'h0F);
`ifdef LFSR_CHK_STOP_ON_ERR_EN
        chk("halt_wc", 32'(word_count), 32'd3);
        chk("halt_ready", 32'(in_ready), 32'd0);
`else
        chk("corrupt_wc", 32'(word_count), 32'd5);
`endif

        // gapped valid
        step(1'b1, 1'b0, 8'h00);
        chk("start_ready", 32'(in_ready), 32'd1);
        foreach (clean_words[i]) begin
            step(1'b0, 1'b1, clean_words[i]);
            step(1'b0, 1'b0, 8'hA5);
            step(1'b0, 1'b0, 8'h5A);
        end
        chk("gap_wc", 32'(word_count), 32'd7);
        chk("gap_ec", 32'(err_count), 32'd0);

        // start colliding with a transfer
        step(1'b1, 1'b1, 8'h55);
        step(1'b0, 1'b1, 8'h55);
        step(1'b0, 1'b1, 8'hAB);
        chk("coll_wc", 32'(word_count), 32'd1);
        chk("coll_ec", 32'(err_count), 32'd0);

        // saturation then asynchronous reset mid-word
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 19; i++) step(1'b0, 1'b1, 8'(m_pred));
        chk("sat_wc", 32'(word_count), 32'hF);
        mid_reset(8'h99);
        chk("rst_wc", 32'(word_count), 32'd0);
        step(1'b0, 1'b1, 8'hFF);
        chk("reseed_locked", 32'(locked), 32'd1);
        step(1'b0, 1'b1, 8'hFF);
        chk("lockup_ec", 32'(err_count), 32'd0);

        // randomized stream with occasional corruption and start pulses
        for (int i = 0; i < 600; i++) begin
            logic [7:0] d;
            logic       s;
            logic       v;
            s = ($urandom_range(0, 59) == 0);
            v = ($urandom_range(0, 9) < 7);
            d = m_locked ? 8'(m_pred) : 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) d = d ^ 8'($urandom_range(1, 255));
            step(s, v, d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
